// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared FSM encoding and width default for serial_subtractor
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - one-bit full subtractor (d = a - b - bin)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial unsigned subtractor, LSB first; SERIAL_SUBTRACTOR_SAT_EN clamps diff to 0 on borrow
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             done_valid,
  input  logic             done_ready
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             bor, d_bit, bor_next;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (bor),
    .d    (d_bit),
    .bout (bor_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_valid) state_next = RUN;
      RUN:     if (cnt == LAST) state_next = DONE;
      DONE:    if (done_ready)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands shift right so bit 0 is always the current bit; result fills from the MSB end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      bor  <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_sh <= a;
            b_sh <= b;
            res  <= '0;
            bor  <= 1'b0;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          res  <= (res >> 1) | (WIDTH'(d_bit) << (WIDTH - 1));
          bor  <= bor_next;
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign done_valid  = (state == DONE);
  assign borrow_out  = bor;

`ifdef SERIAL_SUBTRACTOR_SAT_EN
  assign diff = (done_valid && bor) ? '0 : res;
`else
  assign diff = res;
`endif

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start_valid  input  1  operands on a/b are valid.
REQ-005 start_ready  output  1  block is able to accept operands.
REQ-006 a  input  WIDTH  minuend, unsigned.
REQ-007 b  input  WIDTH  subtrahend, unsigned.
REQ-008 diff  output  WIDTH  result a-b, modulo 2^WIDTH.
REQ-009 borrow_out  output  1  final borrow; 1 when a<b.
REQ-010 done_valid  output  1  diff/borrow_out hold a completed result.
REQ-011 done_ready  input  1  consumer accepts the result.

Function
REQ-012 FSM states are IDLE, RUN and DONE.
REQ-013 IDLE: start_ready=1; when start_valid=1, capture a and b, clear the bit counter and borrow register, and enter RUN.
REQ-014 RUN: process one bit per cycle, LSB first: d = a_i ^ b_i ^ bor; bor_next = (~a_i & b_i) | (~(a_i ^ b_i) & bor).
REQ-015 RUN: shift d into the result register from the MSB end, so that after WIDTH cycles bit i sits at diff[i].
REQ-016 RUN: after exactly WIDTH cycles, enter DONE with borrow_out = the final bor.
REQ-017 Latency: with the start handshake in cycle T, done_valid rises in cycle T+WIDTH+1.
REQ-018 DONE: done_valid=1; diff and borrow_out hold stable until done_ready=1.
REQ-019 DONE with done_ready=1: return to IDLE; start_ready becomes 1 in the next cycle (no same-cycle restart).
REQ-020 start_ready=0 in RUN and DONE; start_valid is ignored there, and a/b changes have no effect once captured.
REQ-021 done_ready is ignored outside DONE.
REQ-022 WIDTH=1: RUN lasts one cycle; behaviour is otherwise identical.
REQ-023 Throughput: one result per WIDTH+2 cycles at most.

Reset
REQ-024 rst_n low forces IDLE immediately, any state, including mid-RUN; an in-flight operation is discarded with no done_valid.
REQ-025 Reset values: start_ready=1, done_valid=0, diff=0, borrow_out=0, counter=0, borrow register=0.

Configuration
REQ-026 Macro SERIAL_SUBTRACTOR_SAT_EN defined: when the final borrow is 1, diff is presented as 0 in DONE; borrow_out still reports 1.
REQ-027 Macro SERIAL_SUBTRACTOR_SAT_EN undefined: diff is always the wrap-around (modulo 2^WIDTH) result.

Structure
REQ-028 Shared package serial_sub_pkg holds the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH default constant.
REQ-029 One sub-module, full_subtractor (inputs a, b, bin; outputs d, bout), implements the REQ-014 equations and is instantiated once.
REQ-030 Counter width is clog2(WIDTH+1) bits.

Verification
REQ-031 WIDTH=8, a=100, b=37 -> diff=63, borrow_out=0, done_valid in cycle T+9.
REQ-032 a=5, b=9 -> diff=252 and borrow_out=1 (macro off); diff=0 and borrow_out=1 (macro on).
REQ-033 a=0,b=0 and a=255,b=255 -> diff=0, borrow_out=0; a=0,b=1 -> diff=255, borrow_out=1 (macro off).
REQ-034 Hold done_ready low for 5 cycles -> done_valid, diff and borrow_out stable; start_valid pulses during RUN/DONE are ignored and start_ready stays 0.
REQ-035 Assert rst_n low at RUN cycle 3 -> IDLE and all REQ-025 reset values; a new operation afterwards completes correctly.
REQ-036 Back-to-back operations with start_valid held high -> second start handshake one cycle after the DONE exit, each result correct.
